// File: rtl/ssd_axis_scanner_if.sv
// ----------------------------------------------------------------------------
// ssd_axis_scanner_if
// Valid/ready stream carrying one segment frame per transfer.
//   s_valid : frame valid (master -> slave)
//   s_ready : frame ready (slave -> master)
//   s_data  : [N_DIGITS-1:0][SEG_W-1:0] segment codes, 1 = lit, digit 0 rightmost
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ssd_axis_scanner_if #(
   parameter int N_DIGITS = 2,
   parameter int SEG_W    = 7
);
   logic                               s_valid;
   logic                               s_ready;
   logic [N_DIGITS-1:0][SEG_W-1:0]     s_data;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/ssd_axis_scanner.sv
// ----------------------------------------------------------------------------
// ssd_axis_scanner
// Stream sink that drives a time-multiplexed seven-segment display. One frame
// is held pending and committed to the display only at the end of a full scan
// (last cycle of the last digit slot), so a scan never mixes two frames.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   s          : slave side of ssd_axis_scanner_if (s_valid/s_ready/s_data)
//   an         : digit enables, one-hot when active, polarity per ACTIVE_LOW
//   seg        : segment drive, polarity per ACTIVE_LOW
//   frame_done : one-cycle pulse after a pending frame is committed
//
// Optional feature: define SSD_BLANK_EN to blank an/seg for the first
// BLANK_CYC cycles of each digit slot (ghosting dead time). Without it the
// digit is driven for the whole slot and BLANK_CYC is unused.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ssd_axis_scanner #(
   parameter int N_DIGITS    = 2,
   parameter int SEG_W       = 7,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   ssd_axis_scanner_if.slave     s,
   output logic [N_DIGITS-1:0]   an,
   output logic [SEG_W-1:0]      seg,
   output logic                  frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);
   // Inactive pin level; XOR with this converts active-high to pin polarity.
   localparam logic INACT = (ACTIVE_LOW != 0);

   typedef logic [N_DIGITS-1:0][SEG_W-1:0] frame_t;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   frame_t              pend_q, pend_d;
   logic                pend_v_q, pend_v_d;
   frame_t              disp_q, disp_d;
   logic                s_ready_q, s_ready_d;
   logic                frame_done_q, frame_done_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]    seg_q, seg_d;

   logic                slot_end;
   logic                boundary;
   logic                lit;
   logic [N_DIGITS-1:0] an_act;
   logic [SEG_W-1:0]    seg_act;

   // NOTE: every variable gets a default at the top of always_comb so that no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      cnt_d        = cnt_q + 1'b1;
      dig_d        = dig_q;
      pend_d       = pend_q;
      pend_v_d     = pend_v_q;
      disp_d       = disp_q;
      frame_done_d = 1'b0;

      slot_end = (cnt_q == CNT_LAST);
      boundary = slot_end && (dig_q == DIG_LAST);

      if (slot_end) begin
         cnt_d = '0;
         dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end

      // s_ready_q is low whenever pend_v_q is high, so a capture and a commit
      // can never happen on the same edge.
      if (s.s_valid && s_ready_q) begin
         pend_d   = s.s_data;
         pend_v_d = 1'b1;
      end

      if (boundary && pend_v_q) begin
         disp_d       = pend_q;
         pend_v_d     = 1'b0;
         frame_done_d = 1'b1;
      end

      s_ready_d = ~pend_v_d;
   end

   // Output stage: registered view of the slot described by cnt_q/dig_q.
   always_comb begin
      an_act  = '0;
      seg_act = '0;
`ifdef SSD_BLANK_EN
      lit = (cnt_q >= CNT_W'(BLANK_CYC));
`else
      lit = 1'b1;
`endif
      if (lit) begin
         an_act[dig_q] = 1'b1;
         seg_act       = disp_q[dig_q];
      end
      an_d  = an_act  ^ {N_DIGITS{INACT}};
      seg_d = seg_act ^ {SEG_W{INACT}};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         dig_q        <= '0;
         pend_q       <= '0;
         pend_v_q     <= 1'b0;
         disp_q       <= '0;
         s_ready_q    <= 1'b0;
         frame_done_q <= 1'b0;
         an_q         <= {N_DIGITS{INACT}};
         seg_q        <= {SEG_W{INACT}};
      end else begin
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         pend_q       <= pend_d;
         pend_v_q     <= pend_v_d;
         disp_q       <= disp_d;
         s_ready_q    <= s_ready_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
      end
   end

   assign s.s_ready  = s_ready_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule
